// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state and mode encodings for the programmable timer
package timer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divide-by-(prescale+1) step generator for the timer
module timer_prescaler #(
   parameter int PRE_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clr,
   input  logic                 en,
   input  logic [PRE_WIDTH-1:0] prescale,
   output logic                 step
);

   logic [PRE_WIDTH-1:0] cnt;

   assign step = en && (cnt == prescale);

   // Wraps at prescale, never at 2^PRE_WIDTH.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= step ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/timer_prog.sv
// rtl/timer_prog.sv - programmable single-channel timer with prescaler, modes, tick and sticky irq
module timer_prog
   import timer_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int PRE_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 mode,
   input  logic [WIDTH-1:0]     load_value,
   input  logic [PRE_WIDTH-1:0] prescale,
   input  logic                 irq_clear,
   output logic [WIDTH-1:0]     count,
   output logic                 running,
   output logic                 tick,
   output logic                 irq
);

   state_t               state;
   logic [WIDTH-1:0]     t_shadow;
   logic [PRE_WIDTH-1:0] p_shadow;
   logic                 mode_shadow;
   logic                 run_en;
   logic                 step;
   logic                 wrap;

   // stop and start both override counting on their edge, so neither can produce a tick.
   assign run_en = (state == ST_RUN) && !stop && !start;
   assign wrap   = step && (count == t_shadow);

   timer_prescaler #(
      .PRE_WIDTH(PRE_WIDTH)
   ) u_prescaler (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (stop | start),
      .en       (run_en),
      .prescale (p_shadow),
      .step     (step)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         running     <= 1'b0;
         count       <= '0;
         t_shadow    <= '0;
         p_shadow    <= '0;
         mode_shadow <= MODE_PERIODIC;
         tick        <= 1'b0;
         irq         <= 1'b0;
      end else begin
         tick <= wrap;
         irq  <= wrap | (irq & ~irq_clear);
         if (stop) begin
            state   <= ST_IDLE;
            running <= 1'b0;
         end else if (start) begin
            t_shadow    <= load_value;
            p_shadow    <= prescale;
            mode_shadow <= mode;
            count       <= '0;
            state       <= ST_RUN;
            running     <= 1'b1;
         end else if (step) begin
            if (count == t_shadow) begin
               count <= '0;
               if (mode_shadow == MODE_ONESHOT) begin
                  state   <= ST_IDLE;
                  running <= 1'b0;
               end else begin
                  // New period length takes effect only at the wrap, keeping the current period intact.
                  t_shadow <= load_value;
               end
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_timer_prog.sv
// tb/tb_timer_prog.sv - self-checking bench for timer_prog
module tb_timer_prog;

   localparam int WIDTH     = 16;
   localparam int PRE_WIDTH = 8;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 start = 1'b0;
   logic                 stop = 1'b0;
   logic                 mode = 1'b0;
   logic [WIDTH-1:0]     load_value = '0;
   logic [PRE_WIDTH-1:0] prescale = '0;
   logic                 irq_clear = 1'b0;
   logic [WIDTH-1:0]     count;
   logic                 running;
   logic                 tick;
   logic                 irq;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: position within the current period, in clock cycles.
   int   m_cyc, m_cnt, m_t, m_p;
   logic m_run, m_tick, m_irq, m_mode;

   typedef struct {
      logic s, sp, m, ic;
      int   lv, pv;
      int   e_cnt;
      logic e_run, e_tick, e_irq;
   } vec_t;

   vec_t tbl[18];

   timer_prog #(.WIDTH(WIDTH), .PRE_WIDTH(PRE_WIDTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .stop       (stop),
      .mode       (mode),
      .load_value (load_value),
      .prescale   (prescale),
      .irq_clear  (irq_clear),
      .count      (count),
      .running    (running),
      .tick       (tick),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cyc = 0; m_cnt = 0; m_t = 0; m_p = 0;
      m_run = 0; m_tick = 0; m_irq = 0; m_mode = 0;
   endtask

   task automatic model_update();
      logic new_tick;
      new_tick = 1'b0;
      if (stop) begin
         m_run = 0;
      end else if (start) begin
         m_t = int'(load_value); m_p = int'(prescale); m_mode = mode;
         m_cyc = 0; m_cnt = 0; m_run = 1;
      end else if (m_run) begin
         m_cyc++;
         if (m_cyc == (m_t + 1) * (m_p + 1)) begin
            new_tick = 1'b1;
            m_cyc = 0;
            m_cnt = 0;
            if (m_mode) m_run = 0;
            else m_t = int'(load_value);
         end else begin
            m_cnt = m_cyc / (m_p + 1);
         end
      end
      m_tick = new_tick;
      m_irq  = new_tick | (m_irq & !irq_clear);
   endtask

   task automatic step(input logic s, input logic sp, input logic ic);
      start = s; stop = sp; irq_clear = ic;
      @(posedge clk);
      model_update();
      #1;
      chk("model_count", int'(count), m_cnt);
      chk("model_running", int'(running), int'(m_run));
      chk("model_tick", int'(tick), int'(m_tick));
      chk("model_irq", int'(irq), int'(m_irq));
   endtask

   task automatic cfg(input logic m, input int lv, input int pv);
      mode = m; load_value = WIDTH'(lv); prescale = PRE_WIDTH'(pv);
   endtask

   initial begin
      int ticks_seen, tick_at, last_tick, guard;
      int tick_idx[$];

      tbl[0]  = '{1,0,0,0, 3,0, 0,1,0,0};
      tbl[1]  = '{0,0,0,0, 3,0, 1,1,0,0};
      tbl[2]  = '{0,0,0,0, 3,0, 2,1,0,0};
      tbl[3]  = '{0,0,0,0, 3,0, 3,1,0,0};
      tbl[4]  = '{0,0,0,0, 3,0, 0,1,1,1};
      tbl[5]  = '{0,0,0,1, 3,0, 1,1,0,0};
      tbl[6]  = '{0,0,0,0, 3,0, 2,1,0,0};
      tbl[7]  = '{0,0,0,0, 3,0, 3,1,0,0};
      tbl[8]  = '{0,0,0,0, 3,0, 0,1,1,1};
      tbl[9]  = '{0,0,0,0, 3,0, 1,1,0,1};
      tbl[10] = '{1,1,0,0, 3,0, 1,0,0,1};
      tbl[11] = '{0,0,0,0, 3,0, 1,0,0,1};
      tbl[12] = '{0,0,0,1, 3,0, 1,0,0,0};
      tbl[13] = '{1,0,0,0, 3,0, 0,1,0,0};
      tbl[14] = '{0,0,0,0, 3,0, 1,1,0,0};
      tbl[15] = '{0,0,0,0, 3,0, 2,1,0,0};
      tbl[16] = '{0,0,0,0, 3,0, 3,1,0,0};
      tbl[17] = '{0,0,0,0, 3,0, 0,1,1,1};

      model_reset();
      #12;
      chk("reset_count", int'(count), 0);
      chk("reset_running", int'(running), 0);
      chk("reset_tick", int'(tick), 0);
      chk("reset_irq", int'(irq), 0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Periodic T=3 P=0, irq clear, stop+start collision, clean restart.
      for (int i = 0; i < 18; i++) begin
         cfg(tbl[i].m, tbl[i].lv, tbl[i].pv);
         step(tbl[i].s, tbl[i].sp, tbl[i].ic);
         chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].e_cnt);
         chk($sformatf("tbl%0d_running", i), int'(running), int'(tbl[i].e_run));
         chk($sformatf("tbl%0d_tick", i), int'(tick), int'(tbl[i].e_tick));
         chk($sformatf("tbl%0d_irq", i), int'(irq), int'(tbl[i].e_irq));
      end

      // One-shot T=2 P=1: single tick 6 cycles after start.
      cfg(1, 2, 1);
      step(1, 0, 0);
      ticks_seen = 0; tick_at = -1;
      for (int i = 1; i <= 26; i++) begin
         step(0, 0, 0);
         if (tick) begin
            ticks_seen++;
            tick_at = i;
            chk("oneshot_running_at_tick", int'(running), 0);
            chk("oneshot_count_at_tick", int'(count), 0);
         end
      end
      chk("oneshot_ticks", ticks_seen, 1);
      chk("oneshot_tick_cycle", tick_at, 6);

      // Periodic T=4, reload to T=1 mid-period.
      cfg(0, 4, 0);
      step(1, 0, 0);
      tick_idx.delete();
      for (int i = 1; i <= 12; i++) begin
         if (i == 2) load_value = WIDTH'(1);
         step(0, 0, 0);
         if (tick) tick_idx.push_back(i);
      end
      chk("reload_ntick", tick_idx.size(), 4);
      if (tick_idx.size() == 4) begin
         chk("reload_first", tick_idx[0], 5);
         chk("reload_p2", tick_idx[1] - tick_idx[0], 2);
         chk("reload_p3", tick_idx[2] - tick_idx[1], 2);
         chk("reload_p4", tick_idx[3] - tick_idx[2], 2);
      end

      // T=0 P=0: tick every cycle, clear held does not win.
      cfg(0, 0, 0);
      step(1, 0, 1);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1);
         chk("t0_tick", int'(tick), 1);
         chk("t0_irq", int'(irq), 1);
      end
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_count", int'(count), 0);
      chk("async_running", int'(running), 0);
      chk("async_tick", int'(tick), 0);
      chk("async_irq", int'(irq), 0);
      model_reset();
      irq_clear = 1'b0;
      @(posedge clk); #1;
      chk("held_reset_tick", int'(tick), 0);
      reset_n = 1'b1;

      // irq_clear on the tick edge: set wins.
      cfg(0, 1, 0);
      step(1, 0, 1);
      step(0, 0, 1);
      chk("clr_pre_irq", int'(irq), 0);
      step(0, 0, 1);
      chk("clr_tick", int'(tick), 1);
      chk("clr_setwins_irq", int'(irq), 1);

      // Restart at count T-1: no tick, full period afterwards.
      cfg(0, 3, 1);
      step(1, 0, 0);
      guard = 0;
      while (count != WIDTH'(2) && guard < 20) begin
         step(0, 0, 0);
         guard++;
      end
      chk("restart_reach_tm1", int'(guard < 20), 1);
      step(1, 0, 0);
      chk("restart_tick", int'(tick), 0);
      chk("restart_count", int'(count), 0);
      last_tick = -1;
      for (int i = 1; i <= 30 && last_tick < 0; i++) begin
         step(0, 0, 0);
         if (tick) last_tick = i;
      end
      chk("restart_latency", last_tick, 8);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         cfg(1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 3));
         step($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 9) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
